// File: rtl/psum_aggregator.sv
// Pairs queued output addresses with PE partial-sum vectors in order and
// performs a saturating read-modify-write (or overwrite) into the output BRAM.
module psum_aggregator #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LANES      = 6,
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       agg_queue_addr,
    input  logic                        agg_queue_push,
    input  logic                        pe_valid,
    input  logic [LANES*ACC_W-1:0]      pe_psum,
    input  logic                        pe_first,
    output logic                        pe_ready,
    output logic [ADDR_WIDTH-1:0]       out_bram_addr,
    output logic                        out_bram_en,
    output logic                        out_bram_we,
    output logic [LANES*ACC_W-1:0]      out_bram_wdata,
    input  logic [LANES*ACC_W-1:0]      out_bram_rdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        err_overflow,
    output logic                        err_underflow,
    output logic [CNT_W-1:0]            sat_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;
    localparam int unsigned VEC_W = LANES * ACC_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_ADD   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]     count_q, count_d;
    logic [VEC_W-1:0]      psum_q, psum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [VEC_W-1:0]      wdata_q, wdata_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic [CNT_W-1:0]      sat_q, sat_d;

    logic                  accept;
    logic                  do_push;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LANES-1:0]      lane_sat;
    logic [VEC_W-1:0]      clamp_sum;

    assign fifo_full  = (count_q == CNT_FW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign accept     = pe_valid & ready_q;
    // A full queue still takes a push when the same cycle pops the head.
    assign do_push    = agg_queue_push & (~fifo_full | accept);

    // Per-lane signed add with one guard bit, clamped to the ACC_W range.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ACC_W-1:0] rd_lane;
        logic [ACC_W-1:0] ps_lane;
        logic [ACC_W:0]   ext_sum;

        assign rd_lane     = out_bram_rdata[k*ACC_W +: ACC_W];
        assign ps_lane     = psum_q[k*ACC_W +: ACC_W];
        assign ext_sum     = {rd_lane[ACC_W-1], rd_lane} + {ps_lane[ACC_W-1], ps_lane};
        assign lane_sat[k] = ext_sum[ACC_W] ^ ext_sum[ACC_W-1];
        assign clamp_sum[k*ACC_W +: ACC_W] =
            !lane_sat[k]    ? ext_sum[ACC_W-1:0] :
            ext_sum[ACC_W]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                              {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        psum_d   = psum_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        sat_d    = sat_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (accept) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, accept})
            2'b10:   count_d = count_q + CNT_FW'(1);
            2'b01:   count_d = count_q - CNT_FW'(1);
            default: count_d = count_q;
        endcase

        if (agg_queue_push && fifo_full && !accept) begin
            ovf_d = 1'b1;
        end
        if (pe_valid && fifo_empty) begin
            udf_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d = fifo_mem_q[rd_ptr_q];
                    psum_d = pe_psum;
                    en_d   = 1'b1;
                    if (pe_first) begin
                        state_d = S_WRITE;
                        we_d    = 1'b1;
                        wdata_d = pe_psum;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_ADD;
            end
            S_ADD: begin
                state_d = S_WRITE;
                en_d    = 1'b1;
                we_d    = 1'b1;
                wdata_d = clamp_sum;
                if (|lane_sat && sat_q != '1) begin
                    sat_d = sat_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE) && (count_d != '0);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            psum_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            sat_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            psum_q   <= psum_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            en_q     <= en_d;
            we_q     <= we_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            sat_q    <= sat_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem_q[wr_ptr_q] <= agg_queue_addr;
        end
    end

    assign pe_ready       = ready_q;
    assign out_bram_addr  = addr_q;
    assign out_bram_en    = en_q;
    assign out_bram_we    = we_q;
    assign out_bram_wdata = wdata_q;
    assign fifo_count     = count_q;
    assign busy           = busy_q;
    assign err_overflow   = ovf_q;
    assign err_underflow  = udf_q;
    assign sat_count      = sat_q;

endmodule
